// File: rtl/fp_exp_accum.sv
// Sequential FP32 accumulator for a stream of exp() results, such as a softmax denominator.
// It takes one term per cycle through a round-to-nearest-even adder and holds the sum until it is taken.

module fp_add_rne #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  output logic [sig_width+exp_width:0] z
);
  localparam int W   = sig_width + exp_width + 1;
  localparam int M   = sig_width + 1;
  localparam int X   = M + 3;
  localparam int EW  = exp_width + 2;
  localparam [exp_width-1:0] EMAX   = '1;
  localparam [exp_width-1:0] SH_MAX = exp_width'(X + 1);

  logic                 sa, sb, za, zb, ia, ib, na, nb, a_big, sub, bs;
  logic [exp_width-1:0] ea, eb, be, se, diff, sh, lz;
  logic [sig_width-1:0] fa, fb, frac_o;
  logic [M-1:0]         bm, sm;
  logic [2*X-1:0]       wide;
  logic [X-1:0]         big_x, small_x, norm;
  logic [X:0]           s;
  logic [M:0]           mr;
  logic                 rnd_up;
  logic [EW-1:0]        ex;

  always_comb begin
    sa = a[W-1];  ea = a[W-2:sig_width];  fa = a[sig_width-1:0];
    sb = b[W-1];  eb = b[W-2:sig_width];  fb = b[sig_width-1:0];
    // Denormals are flushed to zero; NaN only exists when IEEE handling is enabled.
    za = (ea == '0);
    zb = (eb == '0);
    ia = (ea == EMAX);
    ib = (eb == EMAX);
    na = (ieee_compliance != 0) && ia && (fa != '0);
    nb = (ieee_compliance != 0) && ib && (fb != '0);

    a_big = ({ea, fa} >= {eb, fb});
    bs    = a_big ? sa : sb;
    be    = a_big ? ea : eb;
    se    = a_big ? eb : ea;
    bm    = a_big ? {1'b1, fa} : {1'b1, fb};
    sm    = a_big ? {1'b1, fb} : {1'b1, fa};
    sub   = sa ^ sb;

    // Align the smaller operand and keep guard/round bits plus a sticky LSB.
    diff    = be - se;
    sh      = (diff > SH_MAX) ? SH_MAX : diff;
    wide    = {sm, 3'b000, {X{1'b0}}} >> sh;
    small_x = wide[2*X-1:X] | {{(X-1){1'b0}}, |wide[X-1:0]};
    big_x   = {bm, 3'b000};
    s       = sub ? ({1'b0, big_x} - {1'b0, small_x}) : ({1'b0, big_x} + {1'b0, small_x});

    lz = '0;
    for (int i = 0; i < X; i++) begin
      if (s[i]) lz = exp_width'(X - 1 - i);
    end

    if (s[X]) begin
      norm = {s[X:2], s[1] | s[0]};
      ex   = {2'b00, be} + EW'(1);
    end else begin
      norm = s[X-1:0] << lz;
      ex   = {2'b00, be} - {2'b00, lz};
    end

    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr     = {1'b0, norm[X-1:3]} + {{M{1'b0}}, rnd_up};
    if (mr[M]) begin
      ex     = ex + EW'(1);
      frac_o = mr[M-1:1];
    end else begin
      frac_o = mr[M-2:0];
    end

    if (na || nb) begin
      z = {1'b0, EMAX, 1'b1, {(sig_width-1){1'b0}}};
    end else if (ia) begin
      z = {sa, EMAX, {sig_width{1'b0}}};
    end else if (ib) begin
      z = {sb, EMAX, {sig_width{1'b0}}};
    end else if (za && zb) begin
      z = {sa & sb, {(W-1){1'b0}}};
    end else if (za) begin
      z = b;
    end else if (zb) begin
      z = a;
    end else if (s == '0) begin
      z = '0;
    end else if ($signed(ex) <= 0) begin
      z = {bs, {(W-1){1'b0}}};
    end else if (ex >= {2'b00, EMAX}) begin
      z = {bs, EMAX, {sig_width{1'b0}}};
    end else begin
      z = {bs, ex[exp_width-1:0], frac_o};
    end
  end
endmodule

module fp_exp_accum #(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int CNT_W           = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             n_terms,
  input  logic [sig_width+exp_width:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [sig_width+exp_width:0] sum_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         ovf
);
  localparam int W = sig_width + exp_width + 1;
  localparam [exp_width-1:0] EMAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     acc, add_res;
  logic [CNT_W-1:0] cnt;
  logic             start_take, take;

  fp_add_rne #(
    .sig_width      (sig_width),
    .exp_width      (exp_width),
    .ieee_compliance(ieee_compliance)
  ) u_add (
    .a(acc),
    .b(in_data),
    .z(add_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    start_take = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_take = 1'b1;
          state_nxt  = (n_terms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // A restart presented with the acceptance wins over returning to IDLE.
        if (out_ready) begin
          if (start) begin
            start_take = 1'b1;
            state_nxt  = (n_terms == '0) ? DONE : ACCUM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign take = in_valid && (state == ACCUM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_out <= '0;
    end else if (start_take) begin
      acc     <= '0;
      cnt     <= n_terms;
      ovf     <= 1'b0;
      sum_out <= '0;
    end else if (take) begin
      acc <= add_res;
      cnt <= cnt - CNT_W'(1);
      if (add_res[W-2:sig_width] == EMAX) ovf <= 1'b1;
      if (cnt == CNT_W'(1)) sum_out <= add_res;
    end
  end
endmodule
